// File: rtl/seg7_mux_counter.sv
// Hex/BCD up/down counter with a multiplexed common-anode 7-segment driver.
// Count and scan ticks are clock enables on clk; display outputs are registered.
`timescale 1ns/1ps
module seg7_mux_counter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int REFRESH_HZ = 1000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    bcd,
  input  logic                    blank_lz,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);
  localparam int W        = 4 * NUM_DIGITS;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PW       = $clog2(TICK_DIV);
  localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [W-1:0]          count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic                  bcd_prev_q, bcd_prev_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;

  logic                  tick, scan_tick;
  logic [3:0]            nib, nib_max, sel_nib;
  logic                  carry, zero_above;
  logic [W-1:0]          stepped, clamped;
  logic [NUM_DIGITS-1:0] lead_zero;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick      = (presc_q == PW'(TICK_DIV - 1));
    presc_d   = tick ? '0 : presc_q + PW'(1);
    scan_tick = (scan_q == SW'(SCAN_DIV - 1));
    scan_d    = scan_tick ? '0 : scan_q + SW'(1);
    digit_d   = digit_q;
    if (scan_tick)
      digit_d = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + DW'(1);
  end

  // Ripple the +/-1 through the nibbles; hex and BCD differ only in the nibble maximum.
  always_comb begin
    nib_max = bcd ? 4'd9 : 4'd15;
    carry   = 1'b1;
    nib     = 4'd0;
    stepped = count_q;
    clamped = load_val;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib = count_q[4*k +: 4];
      if (carry) begin
        if (up) begin
          if (nib >= nib_max) nib = 4'd0;
          else begin
            nib   = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) nib = nib_max;
          else begin
            nib   = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
      stepped[4*k +: 4] = nib;
      if (bcd && (load_val[4*k +: 4] > 4'd9)) clamped[4*k +: 4] = 4'd9;
    end

    bcd_prev_d = bcd;
    count_d    = count_q;
    wrap_d     = 1'b0;
    if (bcd != bcd_prev_q) begin
      count_d = '0;
    end else if (load) begin
      count_d = clamped;
    end else if (tick && en) begin
      count_d = stepped;
      wrap_d  = carry;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lead_zero  = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead_zero[k] = zero_above && (count_q[4*k +: 4] == 4'd0);
      zero_above   = lead_zero[k];
    end
    sel_nib = count_q[4*int'(digit_q) +: 4];
    if (blank_lz && (digit_q != '0) && lead_zero[digit_q]) seg_d = 7'b1111111;
    else                                                    seg_d = hex_to_seg(sel_nib);
    an_d = ~(NUM_DIGITS'(1) << digit_q);
    dp_d = ~((digit_q == '0) && !en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      scan_q     <= '0;
      digit_q    <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      bcd_prev_q <= bcd_prev_d;
      seg_q      <= 7'b1111111;
      an_q       <= '1;
      dp_q       <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      scan_q     <= scan_d;
      digit_q    <= digit_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      bcd_prev_q <= bcd_prev_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
endmodule

// File: tb/tb_seg7_mux_counter.sv
// Directed scoreboard bench for seg7_mux_counter (TICK_DIV=10, SCAN_DIV=5, 4 digits).
`timescale 1ns/1ps
module tb_seg7_mux_counter;
  logic        clk = 1'b0;
  logic        reset, en, up, bcd, blank_lz, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        wrap;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef enum int {K_COUNT, K_WRAP, K_SEG, K_AN, K_DP} kind_t;
  typedef struct {
    kind_t       kind;
    logic [15:0] exp;
    string       tag;
  } exp_t;
  exp_t sb[$];

  seg7_mux_counter #(
    .CLK_HZ(100), .TICK_HZ(10), .REFRESH_HZ(5), .NUM_DIGITS(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .bcd(bcd),
    .blank_lz(blank_lz), .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] seg_model(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Displayed digit after edge c reflects the scan index held before that edge.
  function automatic int digit_model(input int c);
    return ((c - 1) / 5) % 4;
  endfunction

  function automatic logic [3:0] an_model(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << digit_model(c));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to_tick();
    do step(); while (cyc % 10 != 0);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic b,
                               input logic z, input logic l, input logic [15:0] v);
    reset    = r;
    en       = e;
    up       = u;
    bcd      = b;
    blank_lz = z;
    load     = l;
    load_val = v;
  endtask

  task automatic expectVal(input kind_t k, input logic [15:0] v, input string t);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.tag  = t;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_COUNT: obs = count;
        K_WRAP:  obs = {15'b0, wrap};
        K_SEG:   obs = {9'b0, seg};
        K_AN:    obs = {12'b0, an};
        default: obs = {15'b0, dp};
      endcase
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s at cycle %0d: observed %h required %h", e.tag, cyc, obs, e.exp);
      end
    end
  endtask

  initial begin
    int dg;

    // Reset and first counts / anode scan.
    applyStimulus(1, 0, 1, 0, 0, 0, 16'h0000);
    repeat (3) step();
    expectVal(K_COUNT, 16'h0000, "rst_count");
    expectVal(K_WRAP,  16'h0000, "rst_wrap");
    expectVal(K_SEG,   16'h007F, "rst_seg");
    expectVal(K_AN,    16'h000F, "rst_an");
    expectVal(K_DP,    16'h0001, "rst_dp");
    checkOutput();

    applyStimulus(0, 1, 1, 0, 0, 0, 16'h0000);
    cyc = 0;
    for (int k = 1; k <= 21; k++) begin
      step();
      expectVal(K_AN,    {12'b0, an_model(cyc)}, "t1_an");
      expectVal(K_COUNT, 16'(cyc / 10),          "t1_count");
      expectVal(K_WRAP,  16'h0000,               "t1_wrap");
      if (k == 1) expectVal(K_SEG, {9'b0, seg_model(4'h0)}, "t1_seg_first");
      checkOutput();
    end

    // Hex up wrap through FFFF.
    applyStimulus(0, 1, 1, 0, 0, 1, 16'hFFFE);
    step();
    expectVal(K_COUNT, 16'hFFFE, "t2_load");
    checkOutput();
    applyStimulus(0, 1, 1, 0, 0, 0, 16'h0000);
    run_to_tick();
    expectVal(K_COUNT, 16'hFFFF, "t2_ffff");
    expectVal(K_WRAP,  16'h0000, "t2_nowrap");
    checkOutput();
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 20; k++) begin
      step();
      expectVal(K_SEG,   {9'b0, seg_model(4'hF)}, "t2_seg_F");
      expectVal(K_COUNT, 16'hFFFF,                "t2_hold");
      checkOutput();
    end
    applyStimulus(0, 1, 1, 0, 0, 0, 16'h0000);
    run_to_tick();
    expectVal(K_COUNT, 16'h0000, "t2_wrap_count");
    expectVal(K_WRAP,  16'h0001, "t2_wrap_pulse");
    checkOutput();
    step();
    expectVal(K_WRAP, 16'h0000, "t2_wrap_one_cycle");
    checkOutput();

    // BCD up carry, down borrow with wrap, load clamp.
    applyStimulus(0, 1, 1, 1, 0, 0, 16'h0000);
    step();
    applyStimulus(0, 1, 1, 1, 0, 1, 16'h0199);
    step();
    expectVal(K_COUNT, 16'h0199, "t3_load199");
    checkOutput();
    applyStimulus(0, 1, 1, 1, 0, 0, 16'h0000);
    run_to_tick();
    expectVal(K_COUNT, 16'h0200, "t3_bcd_carry");
    expectVal(K_WRAP,  16'h0000, "t3_no_wrap");
    checkOutput();
    applyStimulus(0, 1, 0, 1, 0, 1, 16'h0000);
    step();
    applyStimulus(0, 1, 0, 1, 0, 0, 16'h0000);
    run_to_tick();
    expectVal(K_COUNT, 16'h9999, "t3_bcd_borrow");
    expectVal(K_WRAP,  16'h0001, "t3_down_wrap");
    checkOutput();
    applyStimulus(0, 1, 0, 1, 0, 1, 16'hAB12);
    step();
    expectVal(K_COUNT, 16'h9912, "t3_clamp");
    expectVal(K_WRAP,  16'h0000, "t3_load_nowrap");
    checkOutput();

    // Blanking and pause indicator.
    applyStimulus(0, 0, 0, 1, 1, 1, 16'h0042);
    step();
    applyStimulus(0, 0, 0, 1, 1, 0, 16'h0000);
    for (int k = 0; k < 20; k++) begin
      step();
      dg = digit_model(cyc);
      expectVal(K_AN, {12'b0, an_model(cyc)}, "t4_an");
      if (dg >= 2)      expectVal(K_SEG, 16'h007F, "t4_blank");
      else if (dg == 1) expectVal(K_SEG, {9'b0, seg_model(4'h4)}, "t4_digit1");
      else              expectVal(K_SEG, {9'b0, seg_model(4'h2)}, "t4_digit0");
      expectVal(K_DP,    (dg == 0) ? 16'h0000 : 16'h0001, "t4_dp");
      expectVal(K_COUNT, 16'h0042, "t4_pause_hold");
      checkOutput();
    end

    // Priority: load beats tick, mode change beats load.
    applyStimulus(0, 1, 1, 1, 0, 0, 16'h0000);
    while (cyc < 109) step();
    applyStimulus(0, 1, 1, 1, 0, 1, 16'h0357);
    step();
    expectVal(K_COUNT, 16'h0357, "t5_load_vs_tick");
    checkOutput();
    applyStimulus(0, 1, 1, 1, 0, 0, 16'h0000);
    run_to_tick();
    expectVal(K_COUNT, 16'h0358, "t5_next_tick");
    checkOutput();
    applyStimulus(0, 1, 1, 0, 0, 1, 16'h1234);
    step();
    expectVal(K_COUNT, 16'h0000, "t5_clear_vs_load");
    checkOutput();
    applyStimulus(0, 1, 1, 0, 0, 1, 16'h1234);
    step();
    expectVal(K_COUNT, 16'h1234, "t5_hex_load");
    checkOutput();
    applyStimulus(0, 1, 1, 1, 0, 0, 16'h0000);
    step();
    expectVal(K_COUNT, 16'h0000, "t5_mode_clear");
    checkOutput();

    // Reset in the middle of a scan frame.
    applyStimulus(0, 1, 1, 1, 0, 1, 16'h1234);
    step();
    applyStimulus(0, 1, 1, 1, 0, 0, 16'h0000);
    repeat (3) step();
    applyStimulus(1, 1, 1, 1, 0, 0, 16'h0000);
    step();
    expectVal(K_AN,    16'h000F, "t5_rst_an");
    expectVal(K_SEG,   16'h007F, "t5_rst_seg");
    expectVal(K_COUNT, 16'h0000, "t5_rst_count");
    expectVal(K_DP,    16'h0001, "t5_rst_dp");
    checkOutput();
    applyStimulus(0, 1, 1, 1, 0, 0, 16'h0000);
    step();
    expectVal(K_AN,  16'h000E, "t5_first_anode");
    expectVal(K_SEG, {9'b0, seg_model(4'h0)}, "t5_first_seg");
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_mux_counter.md
# seg7_mux_counter

Parametrised free-running up/down counter with a multiplexed, common-anode 7-segment display driver for N digits. It counts in hex or BCD at a prescaled tick rate, supports parallel load, pause and leading-zero blanking, and scans the digits at a configurable refresh rate. It sits directly behind the board pins (`seg`/`an`/`dp`) and replaces single-purpose counter/display tops. All sequential logic runs on `clk` only; the count tick and the scan tick are clock enables, never derived clocks.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `TICK_HZ`, 1: count rate. `TICK_DIV = CLK_HZ/TICK_HZ` (floor), must be ≥ 2.
- `REFRESH_HZ`, 1000: full-frame refresh rate. `SCAN_DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS)` (floor), must be ≥ 1.
- `NUM_DIGITS`, 4: number of digits, 1..8. `W = 4*NUM_DIGITS`.
- `clk` input 1: system clock.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `en` input 1: count enable (pause when low).
- `up` input 1: 1 = count up, 0 = count down.
- `bcd` input 1: 1 = decimal (each nibble 0–9), 0 = hex.
- `blank_lz` input 1: enable leading-zero blanking.
- `load` input 1: synchronous parallel load strobe.
- `load_val` input W: value for load.
- `count` output W: current count, nibble k = digit k.
- `wrap` output 1: one-cycle pulse on full-range wrap.
- `seg` output 7: segments a..g on bits 0..6, active low.
- `an` output NUM_DIGITS: digit anodes, active low, at most one low.
- `dp` output 1: decimal point, active low.

## Operation
- **Prescaler.** Counts 0..`TICK_DIV`-1 and wraps. `tick` is high for one cycle when the prescaler equals `TICK_DIV`-1. The prescaler runs regardless of `en`, `load` and `bcd`.
- **Count update priority** (evaluated on each edge):
  1. `reset`
  2. `bcd` changed since the last cycle: clear `count` to 0.
  3. `load`: `count <= load_val`. In BCD mode any nibble > 9 is clamped to 9.
  4. `tick & en`: step by ±1.
  5. Otherwise hold.
- **Hex mode.** Plain W-bit ±1 with modulo wrap.
- **BCD mode.** Per-nibble decimal carry and borrow. Up past 9 gives 0 and carries; down below 0 gives 9 and borrows.
- **`wrap`.**
  - Pulses when up from all-F (hex) or all-9 (BCD) goes to 0.
  - Pulses when down from 0 goes to all-F or all-9.
  - Never pulses on load or on mode-change clear.
- **Scan.**
  - A scan divider produces a one-cycle `scan_tick` every `SCAN_DIV` cycles.
  - Digit index `d` steps 0..`NUM_DIGITS`-1 and wraps.
  - `an[d]` is low and all other anodes are high.
- **Decode (active low, g..a).**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Blanking.** With `blank_lz`=1, digit k > 0 shows `seg`=1111111 when nibble k and all higher nibbles are 0. Digit 0 is never blanked.
- **Decimal point.** `dp` is low only while `d`=0 and `en`=0 (pause indicator); otherwise it is high.

## Timing
- **Reset values.**
  - `count`=0, `wrap`=0.
  - Prescaler, scan divider and `d` all 0.
  - `seg`=1111111, `an` all 1, `dp`=1.
- **First outputs after reset.** The first anode drive appears on the edge after reset deasserts.
- **Count latency.** `count` changes on the same edge where `tick & en` is sampled high. `count` is a register output with no combinational path from inputs.
- **`wrap` timing.** `wrap` is registered and asserted in the same cycle that `count` shows the wrapped value.
- **Display latency.** `seg`, `an` and `dp` are registered, with 1-cycle latency from `d`/`count`. `an` and `seg` always change on the same edge, so there is no ghosting cycle.
- **Simultaneous events.**
  - `load` with `tick & en`: load wins and that tick is lost.
  - A `bcd` toggle together with `load`: the clear wins.
- **Reset mid-operation.** All state returns to the reset values on that edge. There is no partial display frame afterwards.
- **Input sampling.** `up` is sampled only on tick edges, so direction changes take effect at the next tick.

## Test plan
Bench parameters: `CLK_HZ`=100, `TICK_HZ`=10 (`TICK_DIV`=10), `REFRESH_HZ`=5, `NUM_DIGITS`=4 (`SCAN_DIV`=5).

1. **Reset and first count.** Reset 3 cycles, then `en`=1, `up`=1, hex.
   - `count` goes 0→1 on cycle 10 after release, 0→2 on cycle 20.
   - `an` cycles 1110→1101→1011→0111 every 5 cycles.
2. **Hex up wrap.** Load FFFE, `en`=1, `up`=1.
   - FFFF, then 0000 with `wrap`=1 for exactly one cycle.
   - `seg` shows 0001110 on every digit while at FFFF.
3. **BCD up and down.**
   - Load 0199 with `bcd`=1, `up`=1 → next tick gives 0200.
   - Load 0000 with `up`=0 → next tick gives 9999 with `wrap`=1.
   - Load AB12 → `count`=9912.
4. **Blanking and pause.**
   - `count`=0042, `blank_lz`=1 → digits 3,2 show 1111111; digit 1 shows 0011001; digit 0 shows 0100100.
   - With `en`=0, `dp`=0 only during digit 0, and `count` holds.
5. **Priority and mid-operation reset.**
   - `load` coincident with a tick → `count`=`load_val` exactly.
   - Toggle `bcd` with `count`=1234 → `count`=0.
   - Assert `reset` mid-scan → `an`=1111, `seg`=1111111 and `count`=0 on the next edge.
